dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/dcache_array.sv | 41 ++++
 rtl/dcache.sv | 145 ++++++++++++++
 tb/tb_dcache.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data cache: controller state encoding and the stored line record.
// Line fields are sized for the widest supported datapath (NBITS <= LINE_W_MAX).
package riscv_pkg;

  localparam int LINE_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RESP
  } dcache_state_t;

  typedef struct packed {
    logic                  valid;
    logic [LINE_W_MAX-1:0] tag;
    logic [LINE_W_MAX-1:0] data;
  } dcache_line_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid storage for the direct-mapped cache: one combinational read port,
// one synchronous write port, valid bits cleared in bulk on reset.
module dcache_array
  import riscv_pkg::*;
#(
  parameter int NLINES = 8,
  parameter int IDXW   = $clog2(NLINES)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [IDXW-1:0] rd_idx,
  output dcache_line_t rd_line,
  input  logic         wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  dcache_line_t wr_line
);

  logic [NLINES-1:0]     valid_q;
  logic [LINE_W_MAX-1:0] tag_mem  [NLINES];
  logic [LINE_W_MAX-1:0] data_mem [NLINES];

  // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_line.valid;
    end
  end

  // NOTE: tag/data RAM has no reset; contents are ignored until the line's valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_line.tag;
      data_mem[wr_idx] <= wr_line.data;
    end
  end

  assign rd_line = '{valid: valid_q[rd_idx], tag: tag_mem[rd_idx], data: data_mem[rd_idx]};

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate data cache.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache
  import riscv_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int NLINES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] rdata,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = NBITS - IDXW - 2;

  dcache_state_t    state_q, state_d;
  dcache_line_t     rd_line, wr_line;
  logic [IDXW-1:0]  idx;
  logic [TAGW-1:0]  tag;
  logic [NBITS-1:0] word_addr;
  logic             hit, arr_we, fill_start, hit_done;

  assign idx       = addr[IDXW+1:2];
  assign tag       = addr[NBITS-1:IDXW+2];
  assign word_addr = addr & ~NBITS'(3);
  assign hit       = rd_line.valid && (rd_line.tag == LINE_W_MAX'(tag));

  dcache_array #(
    .NLINES (NLINES),
    .IDXW   (IDXW)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .rd_idx  (idx),
    .rd_line (rd_line),
    .wr_en   (arr_we),
    .wr_idx  (idx),
    .wr_line (wr_line)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rdata      = '0;
    arr_we     = 1'b0;
    wr_line    = rd_line;
    fill_start = 1'b0;
    hit_done   = 1'b0;
    // Reset forces every output low and blocks any pending line update this cycle.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (MemWrite) begin
            busy    = 1'b1;
            state_d = WRITE;
          end else if (MemRead) begin
            if (hit) begin
              rdata    = NBITS'(rd_line.data);
              hit_done = 1'b1;
            end else begin
              busy       = 1'b1;
              fill_start = 1'b1;
              state_d    = FILL;
            end
          end
        end
        FILL: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_addr = word_addr;
          if (mem_ack) begin
            arr_we  = 1'b1;
            wr_line = '{valid: 1'b1, tag: LINE_W_MAX'(tag), data: LINE_W_MAX'(mem_rdata)};
            state_d = RESP;
          end
        end
        WRITE: begin
          busy      = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = word_addr;
          mem_wdata = wdata;
          if (mem_ack) begin
            arr_we       = hit;
            wr_line.data = LINE_W_MAX'(wdata);
            state_d      = RESP;
          end
        end
        RESP: begin
          rdata   = NBITS'(rd_line.data);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit_done && hit_count_q != 16'hFFFF)    hit_count_q  <= hit_count_q + 16'd1;
      if (fill_start && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats;
  assign unused_stats = hit_done ^ fill_start;
`endif

endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache: a word-level cache/memory model predicts each
// access; a monitor pops predictions and compares data, busy length and memory traffic.
`timescale 1ns/1ps
module tb_dcache;

  localparam int NBITS  = 8;
  localparam int NLINES = 8;
  localparam int NWORDS = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic [NBITS-1:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic             MemRead, MemWrite, busy, mem_req, mem_we, mem_ack;
`ifdef DCACHE_STATS_EN
  logic [15:0]      hit_count, miss_count;
`endif

  always #5 clock = ~clock;

  dcache #(.NBITS(NBITS), .NLINES(NLINES)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         busy;
    int         reqs;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] model_mem [NWORDS];
  bit         model_valid [NLINES];
  int         model_word [NLINES];
  logic [7:0] back_mem [NWORDS];
  int         ack_lat = 1;
  int         resp_cnt = 0;
  bit         mon_en = 1'b0;
  int         busy_cnt = 0, req_cnt = 0;
  logic       prev_req = 1'b0;
  int         n_checks = 0, n_pass = 0;
  logic [7:0] r_addr;
  int         r_kind;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLINES; i++) model_valid[i] = 1'b0;
  endtask

  // Backing memory: acks in the ack_lat-th consecutive cycle of mem_req.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) begin
        resp_cnt++;
        if (resp_cnt == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = back_mem[mem_addr[7:2]];
          if (mem_we) back_mem[mem_addr[7:2]] = mem_wdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
        end
      end else begin
        resp_cnt = 0;
        mem_ack  = 1'b0;
      end
    end
  end

  // Monitor: counts busy cycles and mem_req transactions, compares on completion.
  initial begin
    forever begin
      @(negedge clock);
      if (!mon_en || reset) begin
        busy_cnt = 0;
        req_cnt  = 0;
        prev_req = 1'b0;
      end else if (MemRead || MemWrite) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_access", sb_q.size(), 1);
        end else begin
          mon_e = sb_q[0];
          if (busy) begin
            busy_cnt++;
            if (mem_req) begin
              if (!prev_req) req_cnt++;
              check("mem_addr", mem_addr, {mon_e.addr[7:2], 2'b00});
              check("mem_we", mem_we, mon_e.is_write);
              if (mon_e.is_write) check("mem_wdata", mem_wdata, mon_e.wdata);
            end
            prev_req = mem_req;
          end else begin
            void'(sb_q.pop_front());
            if (!mon_e.is_write) check("rdata", rdata, mon_e.rdata);
            check("busy_cycles", busy_cnt, mon_e.busy);
            check("mem_req_count", req_cnt, mon_e.reqs);
            busy_cnt = 0;
            req_cnt  = 0;
            prev_req = 1'b0;
          end
        end
      end
    end
  end

  // Predict from word-level rules, push the expectation, drive until busy drops.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] wd, input int lat);
    exp_t e;
    int   w, li;
    bit   hit, done;
    w   = int'(a[7:2]);
    li  = w % NLINES;
    hit = model_valid[li] && (model_word[li] == w);
    e.is_write = wr;
    e.addr     = a;
    e.wdata    = wd;
    e.rdata    = model_mem[w];
    if (!wr && hit) begin
      e.busy = 0;
      e.reqs = 0;
    end else begin
      e.busy = lat + 1;
      e.reqs = 1;
    end
    if (wr) model_mem[w] = wd;
    else if (!hit) begin
      model_valid[li] = 1'b1;
      model_word[li]  = w;
    end
    sb_q.push_back(e);
    ack_lat  = lat;
    addr     = a;
    wdata    = wd;
    MemRead  = rd;
    MemWrite = wr;
    done     = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      #1;
      if (!busy) done = 1'b1;
    end
    if (!done) check("access_timeout", busy, 0);
    @(posedge clock);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    for (int i = 0; i < NWORDS; i++) begin
      back_mem[i]  = 8'($urandom);
      model_mem[i] = back_mem[i];
    end
    back_mem[4]  = 8'hA5;
    model_mem[4] = 8'hA5;
    model_reset();

    // Outputs must be forced low while reset is held, even with requests present.
    @(posedge clock);
    #1;
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    addr     = 8'h10;
    wdata    = 8'hFF;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mon_en   = 1'b1;

    access(1'b1, 1'b0, 8'h10, 8'h00, 3);
    access(1'b1, 1'b0, 8'h10, 8'h00, 3);
    access(1'b0, 1'b1, 8'h10, 8'h3C, 2);
    access(1'b1, 1'b0, 8'h10, 8'h00, 2);
    access(1'b1, 1'b0, 8'h30, 8'h00, 1);
    access(1'b1, 1'b0, 8'h10, 8'h00, 2);
    access(1'b1, 1'b1, 8'h30, 8'h77, 1);
    access(1'b1, 1'b0, 8'h10, 8'h00, 1);

    // Reset during the second FILL cycle aborts the access and drops every valid bit.
    mon_en  = 1'b0;
    ack_lat = 20;
    addr    = 8'h14;
    MemRead = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("fill2_mem_req", mem_req, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_req", mem_req, 0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    MemRead = 1'b0;
    @(negedge clock);
    check("post_abort_mem_req", mem_req, 0);
    model_reset();
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    access(1'b1, 1'b0, 8'h10, 8'h00, 2);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) r_addr = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom)};
      else                           r_addr = 8'($urandom);
      r_kind = $urandom_range(0, 3);
      access(r_kind != 2, r_kind >= 2, r_addr, 8'($urandom), $urandom_range(1, 4));
    end

`ifdef DCACHE_STATS_EN
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    access(1'b1, 1'b0, 8'h40, 8'h00, 1);
    access(1'b1, 1'b0, 8'h44, 8'h00, 2);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1);
    access(1'b1, 1'b0, 8'h44, 8'h00, 1);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1);
    check("miss_count", miss_count, 2);
    check("hit_count", hit_count, 3);
    force dut.hit_count_q = 16'hFFFF;
    @(posedge clock);
    #1;
    release dut.hit_count_q;
    access(1'b1, 1'b0, 8'h40, 8'h00, 1);
    check("hit_count_sat", hit_count, 16'hFFFF);
`endif

    repeat (2) @(posedge clock);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
